// File: rtl/axi_wr_pkg.sv
// rtl/axi_wr_pkg.sv - burst/response encodings and FSM state type for the AXI write burst slave
package axi_wr_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_RESP
  } state_t;

  // WRAP bursts are only meaningful for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_wr_burst_slave_if.sv
// rtl/axi_wr_burst_slave_if.sv - AXI write channels plus downstream beat port, with master/slave views
interface axi_wr_burst_slave_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;

  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  logic                wr_vld;
  logic                wr_rdy;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_strb;
  logic                wr_last;
  logic                wr_err;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    output wr_vld, wr_addr, wr_data, wr_strb, wr_last,
    input  wr_rdy, wr_err
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    input  wr_vld, wr_addr, wr_data, wr_strb, wr_last,
    output wr_rdy, wr_err
  );

endinterface

// File: rtl/axi_wr_aw_fifo.sv
// rtl/axi_wr_aw_fifo.sv - synchronous FIFO holding accepted write-address commands
module axi_wr_aw_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // full comes from the registered count, so a pop never frees a slot for a same-cycle push
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi_wr_burst_slave.sv
// rtl/axi_wr_burst_slave.sv - AXI write burst slave emitting one downstream beat per W beat; WRAP support under AXI_WR_BURST_WRAP_EN
module axi_wr_burst_slave
  import axi_wr_pkg::*;
#(
  parameter int ID_W     = 8,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int AW_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  axi_wr_burst_slave_if.slave bus
);

  localparam int AW_W     = ID_W + ADDR_W + 8 + 3 + 2;
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  logic              aw_push;
  logic              aw_pop;
  logic              aw_full;
  logic              aw_empty;
  logic [AW_W-1:0]   aw_in;
  logic [AW_W-1:0]   aw_out;

  logic [ID_W-1:0]   q_id;
  logic [ADDR_W-1:0] q_addr;
  logic [7:0]        q_len;
  logic [2:0]        q_size;
  logic [1:0]        q_burst;
  logic              q_illegal;

  state_t            state;
  state_t            state_nx;

  logic [ID_W-1:0]   cur_id;
  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        cur_size;
  logic [1:0]        cur_burst;
  logic [7:0]        beat_cnt;
  logic              w_done;
  logic              illegal;
  logic [1:0]        resp_acc;

  logic              wr_vld_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W/8-1:0] wr_strb_q;
  logic              wr_last_q;

  logic              wready;
  logic              bvalid;
  logic              w_hs;
  logic              dn_hs;
  logic              last_beat;
  logic [ADDR_W-1:0] addr_step;
  logic [ADDR_W-1:0] next_addr;

  assign aw_in       = {bus.AWID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST};
  assign {q_id, q_addr, q_len, q_size, q_burst} = aw_out;
  assign bus.AWREADY = ~aw_full;
  assign aw_push     = bus.AWVALID & ~aw_full;

  axi_wr_aw_fifo #(
    .WIDTH (AW_W),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (aw_push),
    .push_data (aw_in),
    .pop       (aw_pop),
    .pop_data  (aw_out),
    .full      (aw_full),
    .empty     (aw_empty)
  );

  // Classify the queued command before it is popped so the burst starts with a known verdict
  always_comb begin
    q_illegal = 1'b0;
    if (q_burst == 2'b11) q_illegal = 1'b1;
    if (q_size > 3'(MAX_SIZE)) q_illegal = 1'b1;
`ifdef AXI_WR_BURST_WRAP_EN
    if ((q_burst == BURST_WRAP) && !wrap_len_ok(q_len)) q_illegal = 1'b1;
`else
    if (q_burst == BURST_WRAP) q_illegal = 1'b1;
`endif
  end

  assign addr_step = ADDR_W'(1) << cur_size;
  assign last_beat = (beat_cnt == 8'd0);
  assign dn_hs     = wr_vld_q & bus.wr_rdy;
  assign w_hs      = bus.WVALID & wready;

`ifdef AXI_WR_BURST_WRAP_EN
  logic [7:0]        cur_len;
  logic [ADDR_W-1:0] wrap_mask;

  assign wrap_mask = ((ADDR_W'(cur_len) + ADDR_W'(1)) << cur_size) - ADDR_W'(1);
`endif

  // Address of the beat after the current one, per burst type
  always_comb begin
    next_addr = cur_addr;
    case (cur_burst)
      BURST_INCR: next_addr = cur_addr + addr_step;
`ifdef AXI_WR_BURST_WRAP_EN
      BURST_WRAP: next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + addr_step) & wrap_mask);
`endif
      default:    next_addr = cur_addr;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // FSM next state and channel handshake outputs
  always_comb begin
    state_nx = state;
    aw_pop   = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!aw_empty) begin
          aw_pop   = 1'b1;
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        // illegal bursts drain W without ever touching the downstream port
        wready = ~w_done & (illegal | ~wr_vld_q | bus.wr_rdy);
        if (illegal) begin
          if (bus.WVALID && wready && last_beat) state_nx = ST_RESP;
        end else if (dn_hs && wr_last_q) begin
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        bvalid = 1'b1;
        if (bus.BREADY) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Burst context, W capture into the downstream register, response accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_id    <= '0;
      cur_addr  <= '0;
      cur_size  <= '0;
      cur_burst <= '0;
      beat_cnt  <= '0;
      w_done    <= 1'b0;
      illegal   <= 1'b0;
      resp_acc  <= RESP_OKAY;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      wr_last_q <= 1'b0;
`ifdef AXI_WR_BURST_WRAP_EN
      cur_len   <= '0;
`endif
    end else begin
      if (aw_pop) begin
        cur_id    <= q_id;
        cur_addr  <= q_addr;
        cur_size  <= q_size;
        cur_burst <= q_burst;
        beat_cnt  <= q_len;
        w_done    <= 1'b0;
        illegal   <= q_illegal;
        resp_acc  <= q_illegal ? RESP_SLVERR : RESP_OKAY;
`ifdef AXI_WR_BURST_WRAP_EN
        cur_len   <= q_len;
`endif
      end
      if (w_hs) begin
        if (!illegal) begin
          wr_vld_q  <= 1'b1;
          wr_addr_q <= cur_addr;
          wr_data_q <= bus.WDATA;
          wr_strb_q <= bus.WSTRB;
          wr_last_q <= last_beat;
          cur_addr  <= next_addr;
        end
        // beat count alone ends the burst; a misplaced WLAST only taints the response
        if (bus.WLAST != last_beat) resp_acc <= RESP_SLVERR;
        if (last_beat) w_done   <= 1'b1;
        else           beat_cnt <= beat_cnt - 8'd1;
      end else if (dn_hs) begin
        wr_vld_q <= 1'b0;
      end
      if (dn_hs && bus.wr_err) resp_acc <= RESP_SLVERR;
    end
  end

  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BID     = cur_id;
  assign bus.BRESP   = resp_acc;
  assign bus.wr_vld  = wr_vld_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_strb = wr_strb_q;
  assign bus.wr_last = wr_last_q;

endmodule

// File: tb/tb_axi_wr_burst_slave.sv
// tb/tb_axi_wr_burst_slave.sv - scoreboard testbench for axi_wr_burst_slave
module tb_axi_wr_burst_slave;
  import axi_wr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  axi_wr_burst_slave_if #(.ID_W(8), .ADDR_W(11), .DATA_W(32)) bus ();

  axi_wr_burst_slave #(
    .ID_W(8), .ADDR_W(11), .DATA_W(32), .AW_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } wbeat_t;

  beat_t      exp_beats[$];
  wbeat_t     w_todo[$];
  logic [9:0] exp_b[$];

  int checks    = 0;
  int errors    = 0;
  int dn_count  = 0;
  int err_idx   = -1;
  int b_low_cnt = 0;
  bit rdy_random = 1'b0;
  bit b_block    = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] bt);
    if (bt == 2'b11 || size > 3'd2) return 1'b0;
`ifdef AXI_WR_BURST_WRAP_EN
    if (bt == 2'b10) return (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
`else
    if (bt == 2'b10) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [10:0] ref_addr(input logic [10:0] start, input int i, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] bt);
    int bytes, win, base, a;
    bytes = 1 << size;
    if (bt == 2'b00) begin
      a = int'(start);
    end else if (bt == 2'b01) begin
      a = (int'(start) + i * bytes) % 2048;
    end else begin
      win  = (int'(len) + 1) * bytes;
      base = int'(start) - (int'(start) % win);
      a    = base + ((int'(start) - base + i * bytes) % win);
    end
    return a[10:0];
  endfunction

  task automatic plan(input logic [7:0] id, input logic [10:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] bt, input int bad_last, input bit exp_err);
    bit legal;
    beat_t b;
    wbeat_t w;
    logic [1:0] resp;
    legal = is_legal(len, size, bt);
    resp  = (!legal || bad_last >= 0 || exp_err) ? 2'b10 : 2'b00;
    for (int i = 0; i <= int'(len); i++) begin
      w.data = $urandom;
      w.strb = 4'($urandom_range(0, 15));
      w.last = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
      w_todo.push_back(w);
      if (legal) begin
        b.addr = ref_addr(addr, i, len, size, bt);
        b.data = w.data;
        b.strb = w.strb;
        b.last = (i == int'(len));
        exp_beats.push_back(b);
      end
    end
    exp_b.push_back({id, resp});
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [10:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] bt);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    @(negedge clk);
    bus.AWVALID = 1'b1;
    bus.AWID    = id;
    bus.AWADDR  = addr;
    bus.AWLEN   = len;
    bus.AWSIZE  = size;
    bus.AWBURST = bt;
    while (!hs && n < 400) begin
      #1;
      hs = bus.AWREADY;
      @(posedge clk);
      if (!hs) begin
        @(negedge clk);
        n++;
      end
    end
    if (!hs) check("aw_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.AWVALID = 1'b0;
  endtask

  task automatic burst(input logic [7:0] id, input logic [10:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bt, input int bad_last, input bit exp_err);
    plan(id, addr, len, size, bt, bad_last, exp_err);
    send_aw(id, addr, len, size, bt);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_b.size() != 0 || w_todo.size() != 0 || exp_beats.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_b.size() + w_todo.size() + exp_beats.size()), 64'd0);
  endtask

  // W channel driver: streams queued beats in order
  initial begin
    bus.WVALID = 1'b0;
    bus.WDATA  = '0;
    bus.WSTRB  = '0;
    bus.WLAST  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || w_todo.size() == 0) begin
        bus.WVALID = 1'b0;
      end else begin
        bus.WVALID = 1'b1;
        bus.WDATA  = w_todo[0].data;
        bus.WSTRB  = w_todo[0].strb;
        bus.WLAST  = w_todo[0].last;
        #1;
        if (bus.WREADY && !rst) begin
          @(posedge clk);
          void'(w_todo.pop_front());
        end
      end
    end
  end

  // Downstream sink: compares accepted beats and checks payload stability while stalled
  initial begin
    beat_t held;
    beat_t b;
    bit    stalled;
    stalled     = 1'b0;
    bus.wr_rdy  = 1'b0;
    bus.wr_err  = 1'b0;
    forever begin
      @(negedge clk);
      bus.wr_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wr_err = (dn_count == err_idx);
      #1;
      if (rst || !bus.wr_vld) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("wr_hold", 64'({bus.wr_addr, bus.wr_data, bus.wr_strb, bus.wr_last}), 64'(held));
        if (bus.wr_rdy) begin
          dn_count++;
          if (exp_beats.size() == 0) begin
            check("beat_unexpected", 64'd1, 64'd0);
          end else begin
            b = exp_beats.pop_front();
            check("wr_addr", 64'(bus.wr_addr), 64'(b.addr));
            check("wr_data", 64'(bus.wr_data), 64'(b.data));
            check("wr_strb", 64'(bus.wr_strb), 64'(b.strb));
            check("wr_last", 64'(bus.wr_last), 64'(b.last));
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = {bus.wr_addr, bus.wr_data, bus.wr_strb, bus.wr_last};
        end
      end
    end
  end

  // B channel sink: in-order response compare, stability while BREADY is low
  initial begin
    logic [9:0] held_b;
    logic [9:0] e;
    bit         stalled;
    stalled    = 1'b0;
    bus.BREADY = 1'b0;
    forever begin
      @(negedge clk);
      if (b_low_cnt > 0 && bus.BVALID) begin
        bus.BREADY = 1'b0;
        b_low_cnt--;
      end else begin
        bus.BREADY = !b_block;
      end
      #1;
      if (rst || !bus.BVALID) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("b_hold", 64'({bus.BID, bus.BRESP}), 64'(held_b));
        if (bus.BREADY) begin
          if (exp_b.size() == 0) begin
            check("b_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_b.pop_front();
            check("bid", 64'(bus.BID), 64'(e[9:2]));
            check("bresp", 64'(bus.BRESP), 64'(e[1:0]));
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_b  = {bus.BID, bus.BRESP};
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int start_cnt;
    bus.AWVALID = 1'b0;
    bus.AWID    = '0;
    bus.AWADDR  = '0;
    bus.AWLEN   = '0;
    bus.AWSIZE  = '0;
    bus.AWBURST = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 64'(bus.AWREADY), 64'd1);
    check("rst_wready",  64'(bus.WREADY),  64'd0);
    check("rst_bvalid",  64'(bus.BVALID),  64'd0);
    check("rst_wr_vld",  64'(bus.wr_vld),  64'd0);
    check("rst_bid",     64'(bus.BID),     64'd0);
    check("rst_bresp",   64'(bus.BRESP),   64'd0);
    check("rst_wr_bus",  64'({bus.wr_addr, bus.wr_data, bus.wr_strb, bus.wr_last}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    burst(8'h11, 11'h010, 8'd3, 3'd2, BURST_INCR, -1, 1'b0);
    wait_idle("drain_incr", 200);
    burst(8'h22, 11'h044, 8'd2, 3'd2, BURST_FIXED, -1, 1'b0);
    wait_idle("drain_fixed", 200);
    burst(8'h33, 11'h7FC, 8'd3, 3'd1, BURST_INCR, -1, 1'b0);
    wait_idle("drain_incr_rollover", 200);
    burst(8'h44, 11'h038, 8'd3, 3'd2, BURST_WRAP, -1, 1'b0);
    wait_idle("drain_wrap", 200);
    burst(8'h45, 11'h038, 8'd2, 3'd2, BURST_WRAP, -1, 1'b0);
    wait_idle("drain_wrap_badlen", 200);
    burst(8'h46, 11'h020, 8'd1, 3'd2, 2'b11, -1, 1'b0);
    wait_idle("drain_burst11", 200);
    burst(8'h47, 11'h020, 8'd1, 3'd3, BURST_INCR, -1, 1'b0);
    wait_idle("drain_bigsize", 200);

    burst(8'h55, 11'h080, 8'd3, 3'd2, BURST_INCR, 1, 1'b0);
    wait_idle("drain_early_wlast", 200);
    err_idx = dn_count + 2;
    burst(8'h56, 11'h0C0, 8'd3, 3'd2, BURST_INCR, -1, 1'b1);
    wait_idle("drain_wr_err", 200);
    err_idx = -1;

    rdy_random = 1'b1;
    b_low_cnt  = 5;
    burst(8'h66, 11'h100, 8'd7, 3'd2, BURST_INCR, -1, 1'b0);
    burst(8'h67, 11'h181, 8'd5, 3'd0, BURST_INCR, -1, 1'b0);
    wait_idle("drain_backpressure", 600);
    rdy_random = 1'b0;

    b_block = 1'b1;
    burst(8'h50, 11'h200, 8'd1, 3'd2, BURST_INCR, -1, 1'b0);
    n = 0;
    while (!bus.BVALID && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("stall_bvalid", 64'(bus.BVALID), 64'd1);
    for (int k = 0; k < 4; k++) begin
      burst(8'(8'h60 + k), 11'(11'h240 + 16 * k), 8'd1, 3'd2, BURST_INCR, -1, 1'b0);
    end
    #1;
    check("aw_full", 64'(bus.AWREADY), 64'd0);
    fork
      burst(8'h64, 11'h2C0, 8'd1, 3'd2, BURST_INCR, -1, 1'b0);
    join_none
    repeat (4) @(negedge clk);
    #1;
    check("aw_still_full", 64'(bus.AWREADY), 64'd0);
    b_block = 1'b0;
    wait_idle("drain_queue", 800);

    burst(8'h70, 11'h300, 8'd7, 3'd2, BURST_INCR, -1, 1'b0);
    start_cnt = dn_count;
    n = 0;
    while (dn_count < start_cnt + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    exp_beats.delete();
    exp_b.delete();
    w_todo.delete();
    @(posedge clk);
    #1;
    check("midrst_awready", 64'(bus.AWREADY), 64'd1);
    check("midrst_wready",  64'(bus.WREADY),  64'd0);
    check("midrst_bvalid",  64'(bus.BVALID),  64'd0);
    check("midrst_wr_vld",  64'(bus.wr_vld),  64'd0);
    check("midrst_b_fields", 64'({bus.BID, bus.BRESP}), 64'd0);
    check("midrst_wr_bus",  64'({bus.wr_addr, bus.wr_data, bus.wr_strb, bus.wr_last}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("post_rst_bvalid", 64'(bus.BVALID), 64'd0);
    check("post_rst_wr_vld", 64'(bus.wr_vld), 64'd0);

    burst(8'h77, 11'h3F0, 8'd1, 3'd2, BURST_INCR, -1, 1'b0);
    wait_idle("drain_after_reset", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_burst_slave.md
AXI_WR_BURST_SLAVE -- requirements
Module: axi_wr_burst_slave

Interface
REQ-001 Parameters SHALL be: ID_W, 8, AXI ID width.
REQ-002 ADDR_W, 11, byte-address width.
REQ-003 DATA_W, 32, data width (32/64/128); strobe width is DATA_W/8.
REQ-004 AW_DEPTH, 4, address-queue depth, a power of two and at least 2.
REQ-005 Ports SHALL be: clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/8/3/2  write-address fields.
REQ-008 AWVALID in 1, AWREADY out 1  address handshake.
REQ-009 WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1  write-data fields.
REQ-010 WVALID in 1, WREADY out 1  data handshake.
REQ-011 BID/BRESP  out  ID_W/2  response fields.
REQ-012 BVALID out 1, BREADY in 1  response handshake.
REQ-013 wr_vld out 1, wr_rdy in 1  downstream beat handshake.
REQ-014 wr_addr/wr_data/wr_strb/wr_last  out  ADDR_W/DATA_W/DATA_W/8/1  downstream beat payload.
REQ-015 wr_err  in  1  downstream error flag, sampled only on wr_vld&wr_rdy.

Function
REQ-016 Queue: on AWVALID&AWREADY, {id,addr,len,size,burst} SHALL be pushed; AWREADY = queue not full, taken from the registered count; a pop on a full queue SHALL NOT free a slot in the same cycle.
REQ-017 FSM states SHALL be IDLE, DATA, RESP; IDLE->DATA one cycle after the queue is non-empty (pop); beat counter loads AWLEN; BRESP accumulator clears to OKAY.
REQ-018 In DATA, WREADY SHALL be (~wr_vld | wr_rdy); a W handshake registers the payload onto wr_* with wr_vld=1 on the next cycle (latency 1); back-to-back beats SHALL be supported at full throughput.
REQ-019 wr_vld/wr_* SHALL hold stable until wr_rdy.
REQ-020 Address, FIXED (00): every beat SHALL use the start address.
REQ-021 Address, INCR (01): the address SHALL advance by 1<<AWSIZE per beat, modulo 2^ADDR_W.
REQ-022 Address, WRAP (10): the address SHALL advance as INCR and wrap within the aligned window of (AWLEN+1)<<AWSIZE bytes.
REQ-023 A burst SHALL always span exactly AWLEN+1 beats; WLAST SHALL NOT terminate it; wr_last=1 on the final beat only.
REQ-024 SLVERR (2'b10) SHALL be latched if WLAST=1 before the final beat or WLAST=0 on the final beat.
REQ-025 SLVERR SHALL be latched if wr_err=1 on any downstream handshake.
REQ-026 Illegal bursts (AWBURST=11; AWSIZE>log2(DATA_W/8); WRAP with AWLEN not in {1,3,7,15}): beats SHALL be accepted with wr_vld never asserted, and BRESP=SLVERR.
REQ-027 DATA->RESP SHALL occur once the final beat is accepted downstream (or accepted on W for an illegal burst); BVALID=1 with BID=queued id; BID and BRESP SHALL hold until BREADY.
REQ-028 RESP->IDLE SHALL occur on BVALID&BREADY; the next burst is popped no earlier than the following cycle.
REQ-029 AW pushes SHALL continue in every state while the queue is not full.

Reset
REQ-030 While rst=1: FSM=IDLE, queue empty, AWREADY=1, WREADY=0, BVALID=0, wr_vld=0, BID=0, BRESP=00, wr_*=0.
REQ-031 Reset asserted mid-burst SHALL abort it without issuing a response; outstanding queued bursts are discarded.

Configuration
REQ-032 Macro AXI_WR_BURST_WRAP_EN defined: WRAP bursts SHALL behave per REQ-022.
REQ-033 Macro undefined: WRAP SHALL be treated as an illegal burst per REQ-026; no wrap logic is synthesised.

Structure
REQ-034 Package axi_wr_pkg SHALL hold the burst encodings (FIXED/INCR/WRAP), response encodings (OKAY/SLVERR), and the FSM state enum.
REQ-035 The address queue SHALL be a separate sub-module, axi_wr_aw_fifo (synchronous FIFO, width/depth parametrised).

Verification
REQ-036 INCR: AWADDR=0x010, AWLEN=3, AWSIZE=2, WLAST on beat 4, wr_rdy=1 -> wr_addr 0x010/0x014/0x018/0x01C, wr_last on the 4th beat only, BRESP=00, BID=AWID.
REQ-037 WRAP (macro defined): AWADDR=0x038, AWLEN=3, AWSIZE=2 -> wr_addr 0x038/0x03C/0x030/0x034; macro undefined -> no wr_vld, BRESP=10.
REQ-038 Queue: 5 AW pushes with AW_DEPTH=4 while the first burst stalls -> AWREADY=0 after the 4th push; all 5 responses return in order with the correct BIDs.
REQ-039 Errors: WLAST on beat 2 of AWLEN=3 -> still 4 beats, BRESP=10; separately, wr_err=1 on beat 3 -> BRESP=10.
REQ-040 Backpressure/reset: wr_rdy toggled randomly and BREADY held low 5 cycles -> payload and BVALID held stable, no beat lost; rst asserted mid-burst -> all outputs at reset values next edge, no BVALID.
